// File: rtl/multi_flag_sync.sv
// Purpose : brings CHANNELS asynchronous flags/levels into the clk domain and decodes each
//           channel into one-cycle event pulses (toggle / rise / fall / debounced level).
// Latency : change settled before edge 1 -> pulse_out on edge SYNC_STAGES+1 (level mode: SYNC_STAGES+FILTER).
// Backpr. : none; events are never stalled. Sticky flags and saturating counters hold status.
//
// Ports:
//   clk, rst_n   destination clock, asynchronous active-low reset
//   async_in     CHANNELS asynchronous inputs
//   mode         2 bits per channel: 00 toggle, 01 rise, 10 fall, 11 debounced level
//   pulse_out    one-cycle event pulse per channel
//   level_out    synchronised (mode 11: filtered) level per channel
//   sticky_out   event flag held until sticky_clr
//   evt_cnt      CNT_W-bit saturating event count per channel; overflow when an event hits saturation
//   cnt_clr      clears evt_cnt and overflow of its channel
module multi_flag_sync #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 3,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       async_in,
    input  logic [2*CHANNELS-1:0]     mode,
    output logic [CHANNELS-1:0]       pulse_out,
    output logic [CHANNELS-1:0]       level_out,
    output logic [CHANNELS-1:0]       sticky_out,
    input  logic [CHANNELS-1:0]       sticky_clr,
    output logic [CHANNELS*CNT_W-1:0] evt_cnt,
    output logic [CHANNELS-1:0]       overflow,
    input  logic [CHANNELS-1:0]       cnt_clr
);

    localparam int ARM_W   = $clog2(SYNC_STAGES + 2);
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam logic [7:0] FILT_LAST = 8'(FILTER - 1);

    // Shared arm counter: events stay disabled until the sync chains hold real
    // input values, so an input that was static through reset raises nothing.
    logic [ARM_W-1:0] armCnt;
    logic             armed;

    assign armed = (armCnt == ARM_W'(ARM_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armCnt <= '0;
        end else if (!armed) begin
            armCnt <= armCnt + ARM_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : gCh
        logic [SYNC_STAGES-1:0] syncQ;
        logic                   sLast;
        logic                   histQ;
        logic                   levelQ;
        logic                   pulseQ;
        logic                   stickyQ;
        logic                   ovfQ;
        logic [1:0]             modeQ;
        logic [7:0]             filtCnt;
        logic [CNT_W-1:0]       cntQ;

        logic [1:0]             modeCur;
        logic                   modeChg;
        logic                   detRaw;
        logic                   pulseNxt;
        logic                   levelNxt;
        logic [7:0]             filtNxt;

        assign sLast   = syncQ[SYNC_STAGES-1];
        assign modeCur = mode[2*i +: 2];
        assign modeChg = (modeCur != modeQ);

        always_comb begin
            detRaw = 1'b0;
            case (modeQ)
                2'b00:   detRaw = sLast ^ histQ;
                2'b01:   detRaw = sLast & ~histQ;
                2'b10:   detRaw = ~sLast & histQ;
                default: detRaw = 1'b0;
            endcase
        end

        always_comb begin
            pulseNxt = 1'b0;
            levelNxt = levelQ;
            filtNxt  = '0;
            if (!armed) begin
                levelNxt = sLast;
            end else if (modeChg) begin
                // Mode switch cycle: no event, filter restarts, level is kept.
                levelNxt = levelQ;
            end else if (modeQ == 2'b11) begin
                // Debounce: only a mismatch lasting FILTER consecutive cycles is accepted.
                if (sLast != levelQ) begin
                    if (filtCnt >= FILT_LAST) begin
                        levelNxt = sLast;
                        pulseNxt = 1'b1;
                    end else begin
                        filtNxt = filtCnt + 8'd1;
                    end
                end
            end else begin
                levelNxt = sLast;
                pulseNxt = detRaw;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                syncQ   <= '0;
                histQ   <= 1'b0;
                levelQ  <= 1'b0;
                pulseQ  <= 1'b0;
                stickyQ <= 1'b0;
                ovfQ    <= 1'b0;
                modeQ   <= 2'b00;
                filtCnt <= '0;
                cntQ    <= '0;
            end else begin
                syncQ   <= {syncQ[SYNC_STAGES-2:0], async_in[i]};
                histQ   <= sLast;
                levelQ  <= levelNxt;
                pulseQ  <= pulseNxt;
                modeQ   <= modeCur;
                filtCnt <= filtNxt;
                // An event arriving with a clear still leaves the flag set.
                stickyQ <= pulseNxt | (stickyQ & ~sticky_clr[i]);
                if (cnt_clr[i]) begin
                    cntQ <= pulseNxt ? CNT_W'(1) : '0;
                    ovfQ <= 1'b0;
                end else if (pulseNxt) begin
                    if (&cntQ) begin
                        ovfQ <= 1'b1;
                    end else begin
                        cntQ <= cntQ + CNT_W'(1);
                    end
                end
            end
        end

        assign pulse_out[i]                 = pulseQ;
        assign level_out[i]                 = levelQ;
        assign sticky_out[i]                = stickyQ;
        assign overflow[i]                  = ovfQ;
        assign evt_cnt[CNT_W*i +: CNT_W]    = cntQ;
    end

endmodule

// File: tb/tb_multi_flag_sync.sv
// Directed bench for multi_flag_sync: CHANNELS=4, SYNC_STAGES=2, FILTER=3, CNT_W=2.
// Channel modes: ch0 toggle, ch1 rise, ch2 fall, ch3 debounced level.
module tb_multi_flag_sync;

    localparam int CH  = 4;
    localparam int STG = 2;
    localparam int FLT = 3;
    localparam int CW  = 2;

    logic            clk;
    logic            rst_n;
    logic [CH-1:0]   async_in;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   pulse_out;
    logic [CH-1:0]   level_out;
    logic [CH-1:0]   sticky_out;
    logic [CH-1:0]   sticky_clr;
    logic [CH*CW-1:0] evt_cnt;
    logic [CH-1:0]   overflow;
    logic [CH-1:0]   cnt_clr;

    int checks = 0;
    int errors = 0;

    logic [CH-1:0] pulseLog [0:31];
    logic [CH-1:0] orAcc;

    multi_flag_sync #(
        .CHANNELS(CH), .SYNC_STAGES(STG), .FILTER(FLT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .mode(mode),
        .pulse_out(pulse_out), .level_out(level_out), .sticky_out(sticky_out),
        .sticky_clr(sticky_clr), .evt_cnt(evt_cnt), .overflow(overflow),
        .cnt_clr(cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; sample and drive 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        async_in   = 4'b1111;
        mode       = {2'b11, 2'b10, 2'b01, 2'b00};
        sticky_clr = '0;
        cnt_clr    = '0;
        repeat (3) step();

        // Reset values with inputs high.
        chk("rst_pulse",  32'(pulse_out),  32'h0);
        chk("rst_level",  32'(level_out),  32'h0);
        chk("rst_sticky", 32'(sticky_out), 32'h0);
        chk("rst_cnt",    32'(evt_cnt),    32'h0);
        chk("rst_ovf",    32'(overflow),   32'h0);

        // Release with inputs static high: level follows after 3 edges, no events.
        rst_n = 1'b1;
        orAcc = '0;
        step(); orAcc |= pulse_out;
        step(); orAcc |= pulse_out;
        chk("level_edge2", 32'(level_out), 32'h0);
        step(); orAcc |= pulse_out;
        chk("level_edge3", 32'(level_out), 32'hF);
        for (int k = 4; k <= 20; k++) begin
            step();
            orAcc |= pulse_out;
        end
        chk("static_no_pulse", 32'(orAcc),   32'h0);
        chk("static_cnt",      32'(evt_cnt), 32'h0);

        // Re-reset with inputs low to start the edge tests from zero.
        rst_n    = 1'b0;
        async_in = 4'b0000;
        step();
        rst_n = 1'b1;
        repeat (6) step();

        // Same 0->1->0 waveform on ch0 (toggle), ch1 (rise), ch2 (fall).
        async_in[2:0] = 3'b111;
        for (int k = 1; k <= 15; k++) begin
            step();
            pulseLog[k] = pulse_out;
            if (k == 10) async_in[2:0] = 3'b000;
        end
        chk("edge_k1",  32'(pulseLog[2]),  32'h0);
        chk("edge_k2",  32'(pulseLog[3]),  32'h3);
        chk("edge_k3",  32'(pulseLog[4]),  32'h0);
        chk("edge_k11", 32'(pulseLog[12]), 32'h0);
        chk("edge_k12", 32'(pulseLog[13]), 32'h5);
        chk("edge_k13", 32'(pulseLog[14]), 32'h0);
        orAcc = '0;
        for (int k = 1; k <= 15; k++) if (k != 3 && k != 13) orAcc |= pulseLog[k];
        chk("edge_quiet",  32'(orAcc),      32'h0);
        chk("edge_cnt",    32'(evt_cnt),    32'h16);
        chk("edge_sticky", 32'(sticky_out), 32'h7);
        chk("edge_level",  32'(level_out),  32'h0);

        // ch3 debounce: 2-cycle glitch rejected.
        async_in[3] = 1'b1;
        orAcc = '0;
        for (int k = 1; k <= 8; k++) begin
            step();
            orAcc |= pulse_out;
            if (k == 2) async_in[3] = 1'b0;
        end
        chk("glitch_pulse", 32'(orAcc[3]),     32'h0);
        chk("glitch_level", 32'(level_out[3]), 32'h0);

        // ch3 debounce: 5-cycle high accepted at edge STG+FLT, release accepted later.
        async_in[3] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            pulseLog[k] = pulse_out;
            if (k == 5) chk("filt_level_hi", 32'(level_out[3]), 32'h1);
            if (k == 5) async_in[3] = 1'b0;
        end
        chk("filt_e4", 32'(pulseLog[4][3]),  32'h0);
        chk("filt_e5", 32'(pulseLog[5][3]),  32'h1);
        chk("filt_e6", 32'(pulseLog[6][3]),  32'h0);
        chk("filt_e9", 32'(pulseLog[9][3]),  32'h0);
        chk("filt_e10", 32'(pulseLog[10][3]), 32'h1);
        chk("filt_level_lo", 32'(level_out[3]), 32'h0);

        // Counter clear on ch0 only.
        cnt_clr = 4'b0001;
        step();
        cnt_clr = '0;
        chk("cntclr_iso", 32'(evt_cnt), 32'h94);

        // Four ch0 events into a 2-bit counter: saturate and overflow.
        for (int n = 0; n < 4; n++) begin
            async_in[0] = ~async_in[0];
            repeat (4) step();
        end
        chk("sat_cnt", 32'(evt_cnt[1:0]), 32'h3);
        chk("sat_ovf", 32'(overflow[0]),  32'h1);

        // Clear coinciding with an event: count 1, overflow cleared.
        async_in[0] = 1'b1;
        repeat (2) step();
        cnt_clr = 4'b0001;
        step();
        cnt_clr = '0;
        chk("clrrace_pulse", 32'(pulse_out[0]),  32'h1);
        chk("clrrace_cnt",   32'(evt_cnt[1:0]), 32'h1);
        chk("clrrace_ovf",   32'(overflow[0]),  32'h0);

        // Sticky on ch1: clear, then clear racing an event, then idle clear.
        sticky_clr = 4'b0010;
        step();
        sticky_clr = '0;
        chk("sticky_clr1", 32'(sticky_out[1]), 32'h0);
        async_in[1] = 1'b1;
        repeat (2) step();
        sticky_clr = 4'b0010;
        step();
        sticky_clr = '0;
        chk("sticky_race_pulse", 32'(pulse_out[1]),  32'h1);
        chk("sticky_race",       32'(sticky_out[1]), 32'h1);
        repeat (3) step();
        sticky_clr = 4'b0010;
        step();
        sticky_clr = '0;
        chk("sticky_idle_clr", 32'(sticky_out[1]), 32'h0);

        // Fall event on ch2, then reset while the pulse is high.
        async_in[2] = 1'b1;
        repeat (4) step();
        async_in[2] = 1'b0;
        repeat (3) step();
        chk("mid_pulse", 32'(pulse_out[2]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pulse",  32'(pulse_out),  32'h0);
        chk("mid_rst_level",  32'(level_out),  32'h0);
        chk("mid_rst_sticky", 32'(sticky_out), 32'h0);
        chk("mid_rst_cnt",    32'(evt_cnt),    32'h0);
        chk("mid_rst_ovf",    32'(overflow),   32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_flag_sync.md
Name: multi_flag_sync

Overview:
Receive-side, multi-channel crossing block that brings CHANNELS asynchronous signals into the local clock domain through a configurable-depth synchroniser. It decodes each channel into single-cycle event pulses, using one of four per-channel modes: toggle, rising edge, falling edge, or debounced level. Per-channel sticky flags and saturating event counters are provided for status registers. It is the generalised successor to the single-channel toggle flag crosser, placed at the destination domain of every inter-domain flag or level.

Parameters:
CHANNELS, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILTER, 3, consecutive stable cycles required in level mode (>=1, <=255)
CNT_W, 8, event counter width per channel (>=1)

Ports:
clk  in  1  destination-domain clock
rst_n  in  1  asynchronous active-low reset
async_in  in  CHANNELS  asynchronous inputs, unrelated to clk
mode  in  2*CHANNELS  per-channel mode, bits [2i+1:2i]; 00 toggle, 01 rise, 10 fall, 11 filtered level; quasi-static
pulse_out  out  CHANNELS  registered one-cycle event pulse
level_out  out  CHANNELS  registered synchronised level (filtered in mode 11)
sticky_out  out  CHANNELS  set by event, held until cleared
sticky_clr  in  CHANNELS  per-channel sticky clear, single-cycle
evt_cnt  out  CHANNELS*CNT_W  per-channel saturating event count, channel i at [CNT_W*i +: CNT_W]
overflow  out  CHANNELS  set when an event arrives with the count already saturated
cnt_clr  in  CHANNELS  per-channel clear of evt_cnt and overflow

Behaviour:
- Reset (async assert, sync release via clk): all flops 0. Outputs after reset: pulse_out=0, level_out=0, sticky_out=0, evt_cnt=0, overflow=0.
- Per channel: sync chain s[0..SYNC_STAGES-1]; s_last = s[SYNC_STAGES-1]; history register h.
- Arming: a shared arm counter runs for SYNC_STAGES+1 cycles after reset release.
  - While disarmed: no events; h<=s_last; level_out<=s_last; filter counters held at 0.
  - Consequence: an input held static through reset produces no event.
- Raw detect term d per mode:
  - 00: s_last^h
  - 01: s_last & ~h
  - 10: ~s_last & h
- Modes 00/01/10, each armed edge: h<=s_last; level_out<=s_last; pulse_out<=d.
- Latency: an input change settled before edge 1 gives pulse_out high from edge SYNC_STAGES+1 to edge SYNC_STAGES+2, exactly one cycle.
- Mode 11 (debounce):
  - Filter counter increments each cycle while s_last != level_out, and clears whenever they are equal.
  - When the counter reaches FILTER: level_out<=s_last, pulse_out<=1 on the same edge, counter<=0.
  - Glitches shorter than FILTER cycles produce no event.
  - Latency from settled input is SYNC_STAGES+FILTER edges.
- Input constraint (modes 00/01/10): successive changes must be separated by >=2 clk periods. Closer changes may merge; no hardware detection.
- Mode change: mode is registered per channel (mode_q).
  - Any change clears that channel's filter counter and suppresses pulse_out for that cycle.
  - level_out continues from its current value.
- Sticky: set when pulse_out is set. sticky_clr clears it. Simultaneous set and clear leaves sticky set (event wins).
- Counter: increments by 1 on each pulse_out, saturating at 2^CNT_W-1.
  - A pulse at saturation sets overflow; the count holds.
  - cnt_clr zeroes count and overflow. Simultaneous cnt_clr and pulse gives count=1, overflow=0.
- Channels fully independent. Clears act only on their own channel.
- Reset mid-operation: immediate clear of all state; re-arms after release; in-flight events are lost.

Test Plan:
- Reset, defaults (CH=4, STG=2, FILTER=3): hold async_in=4'b1111 through reset, release -> no pulse_out for 20 cycles, level_out=4'b1111 after 3 edges, evt_cnt all 0.
- Mode 00 on ch0: toggle async_in[0] 0->1 before edge k, then 1->0 10 cycles later -> two one-cycle pulses at edge k+2 and k+12, evt_cnt[0]=2, sticky_out[0]=1.
- Mode 01 ch1 / 10 ch2: drive the same 0->1->0 waveform on both -> ch1 pulses only on rise, ch2 only on fall, one count each.
- Mode 11 ch3, FILTER=3: 2-cycle glitch -> no pulse, level_out[3]=0; 5-cycle high -> level_out[3]=1 and pulse exactly SYNC_STAGES+3 edges after the change.
- Counter, CNT_W=2: 4 events on ch0 -> evt_cnt[0]=3, overflow[0]=1. Then cnt_clr asserted in the same cycle as a pulse -> evt_cnt[0]=1, overflow[0]=0.
- Sticky race: sticky_clr[1] asserted on the same edge a pulse sets sticky -> sticky_out[1] stays 1. Clear on a later idle cycle -> 0. Assert rst_n low mid-pulse -> all outputs 0 immediately.
